// File: rtl/sort_block_loader.sv
// Captures a NUM_ELEM-element block on start and streams it, element 0 first, into a fifo.
// Optional macro LOADER_PAIR_SORT_EN orders each captured pair (2k,2k+1) ascending.
module sort_block_loader #(
    parameter int DATA_W   = 8,
    parameter int NUM_ELEM = 4,
    parameter int CNT_W    = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [NUM_ELEM*DATA_W-1:0]   data_in_i,
    input  logic                         full_i,
    output logic                         wr_fifo_o,
    output logic [DATA_W-1:0]            w_data_o,
    output logic                         busy_o,
    output logic                         done_o,
    output logic                         start_ign_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ELEM - 1);

    state_t                          state_q, state_d;
    logic [NUM_ELEM-1:0][DATA_W-1:0] buffer_q, buffer_d;
    logic [NUM_ELEM-1:0][DATA_W-1:0] capture;
    logic [CNT_W-1:0]                idx_q, idx_d;
    logic                            start_ign_q, start_ign_d;

    // Block as it will be stored on the capture edge; the optional pair swap lives here
    // so it costs no extra cycle.
    always_comb begin
        capture = data_in_i;
`ifdef LOADER_PAIR_SORT_EN
        for (int k = 0; k + 1 < NUM_ELEM; k += 2) begin
            if (data_in_i[(k+1)*DATA_W +: DATA_W] < data_in_i[k*DATA_W +: DATA_W]) begin
                capture[k]   = data_in_i[(k+1)*DATA_W +: DATA_W];
                capture[k+1] = data_in_i[k*DATA_W +: DATA_W];
            end
        end
`endif
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        buffer_d    = buffer_q;
        start_ign_d = start_ign_q;
        wr_fifo_o   = 1'b0;
        w_data_o    = '0;
        busy_o      = 1'b0;
        done_o      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    buffer_d = capture;
                    idx_d    = '0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                busy_o    = 1'b1;
                wr_fifo_o = !full_i;
                for (int k = 0; k < NUM_ELEM; k++) begin
                    if (idx_q == CNT_W'(k)) begin
                        w_data_o = buffer_q[k];
                    end
                end
                if (start_i) begin
                    start_ign_d = 1'b1;
                end
                // A stalled write simply holds idx; the last accepted element ends the block.
                if (!full_i) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                done_o  = 1'b1;
                idx_d   = '0;
                state_d = IDLE;
                if (start_i) begin
                    start_ign_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            buffer_q    <= '0;
            start_ign_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            buffer_q    <= buffer_d;
            start_ign_q <= start_ign_d;
        end
    end

    assign start_ign_o = start_ign_q;

endmodule

// File: tb/tb_sort_block_loader.sv
// Directed bench for sort_block_loader: a scoreboard queue holds expected fifo writes and a
// negedge monitor pops them; control outputs are checked cycle by cycle from the main thread.
module tb_sort_block_loader;

    localparam int DATA_W   = 8;
    localparam int NUM_ELEM = 4;
    localparam int CNT_W    = 3;

    localparam logic [31:0] BLOCK_A   = 32'h2040_1030;
    localparam logic [31:0] BLOCK_ALT = 32'hDDCC_BBAA;
    localparam logic [31:0] BLOCK_LO  = 32'h0403_0201;
    localparam logic [31:0] BLOCK_HI  = 32'h0807_0605;
    localparam logic [31:0] BLOCK_EQ  = 32'h5555_1030;

`ifdef LOADER_PAIR_SORT_EN
    localparam logic [7:0] A0 = 8'h10, A1 = 8'h30, A2 = 8'h20, A3 = 8'h40;
    localparam logic [7:0] Q0 = 8'h10, Q1 = 8'h30;
`else
    localparam logic [7:0] A0 = 8'h30, A1 = 8'h10, A2 = 8'h40, A3 = 8'h20;
    localparam logic [7:0] Q0 = 8'h30, Q1 = 8'h10;
`endif

    logic                       clk;
    logic                       rst;
    logic                       start;
    logic [NUM_ELEM*DATA_W-1:0] dataIn;
    logic                       full;
    logic                       wrFifo;
    logic [DATA_W-1:0]          wData;
    logic                       busy;
    logic                       done;
    logic                       startIgn;

    int           assertCount = 0;
    int           failCount   = 0;
    logic [7:0]   expectQ[$];

    sort_block_loader #(
        .DATA_W   (DATA_W),
        .NUM_ELEM (NUM_ELEM),
        .CNT_W    (CNT_W)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .data_in_i   (dataIn),
        .full_i      (full),
        .wr_fifo_o   (wrFifo),
        .w_data_o    (wData),
        .busy_o      (busy),
        .done_o      (done),
        .start_ign_o (startIgn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive the next cycle's inputs just after the edge, then wait for mid-cycle sampling.
    task automatic applyStimulus(input logic s, input logic [31:0] d, input logic f);
        @(posedge clk);
        #1;
        start  = s;
        dataIn = d;
        full   = f;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushBlock(input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3);
        expectQ.push_back(e0);
        expectQ.push_back(e1);
        expectQ.push_back(e2);
        expectQ.push_back(e3);
    endtask

    // Every write the DUT presents must match the oldest expected element.
    always @(negedge clk) begin
        if (!rst && wrFifo) begin
            if (expectQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_write: got 0x%0h, expected no write", wData);
            end else begin
                checkOutput("w_data", {24'h0, wData}, {24'h0, expectQ.pop_front()});
            end
        end
    end

    initial begin
        bit doneSeen;
        rst    = 1'b1;
        start  = 1'b0;
        dataIn = '0;
        full   = 1'b0;

        @(negedge clk);
        checkOutput("reset_wr_fifo", {31'h0, wrFifo}, 32'h0);
        checkOutput("reset_w_data", {24'h0, wData}, 32'h0);
        checkOutput("reset_busy", {31'h0, busy}, 32'h0);
        checkOutput("reset_done", {31'h0, done}, 32'h0);
        checkOutput("reset_start_ign", {31'h0, startIgn}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] reset during SEND");
        expectQ.push_back(A0);
        expectQ.push_back(A1);
        applyStimulus(1'b1, BLOCK_A, 1'b0);
        applyStimulus(1'b0, BLOCK_A, 1'b0);
        applyStimulus(1'b0, BLOCK_A, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_mid_wr_fifo", {31'h0, wrFifo}, 32'h0);
        checkOutput("rst_mid_busy", {31'h0, busy}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, BLOCK_A, 1'b0);
            checkOutput("post_rst_idle_wr", {31'h0, wrFifo}, 32'h0);
            checkOutput("post_rst_idle_busy", {31'h0, busy}, 32'h0);
        end
        checkOutput("post_rst_queue_drained", expectQ.size(), 32'h0);

        $display("[TB] plain block");
        pushBlock(A0, A1, A2, A3);
        applyStimulus(1'b1, BLOCK_A, 1'b0);
        checkOutput("start_cycle_busy", {31'h0, busy}, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0, 32'hFFFF_FFFF, 1'b0);
            checkOutput("send_busy", {31'h0, busy}, 32'h1);
            checkOutput("send_wr_fifo", {31'h0, wrFifo}, 32'h1);
            checkOutput("send_done_low", {31'h0, done}, 32'h0);
        end
        applyStimulus(1'b0, BLOCK_A, 1'b0);
        checkOutput("done_pulse", {31'h0, done}, 32'h1);
        checkOutput("done_busy", {31'h0, busy}, 32'h0);
        checkOutput("done_wr_fifo", {31'h0, wrFifo}, 32'h0);
        applyStimulus(1'b0, BLOCK_A, 1'b0);
        checkOutput("done_one_cycle", {31'h0, done}, 32'h0);

        $display("[TB] stall on full");
        pushBlock(A0, A1, A2, A3);
        applyStimulus(1'b1, BLOCK_A, 1'b0);
        applyStimulus(1'b0, BLOCK_A, 1'b0);
        checkOutput("stall_first_write", {31'h0, wrFifo}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, BLOCK_A, 1'b1);
            checkOutput("stall_wr_fifo", {31'h0, wrFifo}, 32'h0);
            checkOutput("stall_w_data_held", {24'h0, wData}, {24'h0, A1});
            checkOutput("stall_busy", {31'h0, busy}, 32'h1);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, BLOCK_A, 1'b0);
            checkOutput("resume_wr_fifo", {31'h0, wrFifo}, 32'h1);
        end
        applyStimulus(1'b0, BLOCK_A, 1'b0);
        checkOutput("stall_done", {31'h0, done}, 32'h1);
        checkOutput("start_ign_still_clear", {31'h0, startIgn}, 32'h0);

        $display("[TB] start during SEND");
        pushBlock(A0, A1, A2, A3);
        applyStimulus(1'b1, BLOCK_A, 1'b0);
        applyStimulus(1'b0, BLOCK_A, 1'b0);
        applyStimulus(1'b1, BLOCK_ALT, 1'b0);
        applyStimulus(1'b0, BLOCK_ALT, 1'b0);
        checkOutput("start_ign_set", {31'h0, startIgn}, 32'h1);
        applyStimulus(1'b0, BLOCK_ALT, 1'b0);
        applyStimulus(1'b0, BLOCK_ALT, 1'b0);
        checkOutput("ign_block_done", {31'h0, done}, 32'h1);
        pushBlock(8'h01, 8'h02, 8'h03, 8'h04);
        applyStimulus(1'b1, BLOCK_LO, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, BLOCK_ALT, 1'b0);
            checkOutput("restart_wr_fifo", {31'h0, wrFifo}, 32'h1);
        end
        applyStimulus(1'b0, BLOCK_ALT, 1'b0);
        checkOutput("restart_done", {31'h0, done}, 32'h1);

        $display("[TB] back-to-back blocks");
        pushBlock(8'h01, 8'h02, 8'h03, 8'h04);
        pushBlock(8'h05, 8'h06, 8'h07, 8'h08);
        applyStimulus(1'b1, BLOCK_LO, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, BLOCK_HI, 1'b0);
            checkOutput("b2b_first_wr", {31'h0, wrFifo}, 32'h1);
        end
        applyStimulus(1'b1, BLOCK_HI, 1'b0);
        checkOutput("b2b_first_done", {31'h0, done}, 32'h1);
        applyStimulus(1'b1, BLOCK_HI, 1'b0);
        checkOutput("b2b_capture_idle_busy", {31'h0, busy}, 32'h0);
        checkOutput("b2b_capture_idle_wr", {31'h0, wrFifo}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, BLOCK_A, 1'b0);
            checkOutput("b2b_second_wr", {31'h0, wrFifo}, 32'h1);
        end
        applyStimulus(1'b0, BLOCK_A, 1'b0);
        checkOutput("b2b_second_done", {31'h0, done}, 32'h1);

        $display("[TB] equal pair block");
        pushBlock(Q0, Q1, 8'h55, 8'h55);
        applyStimulus(1'b1, BLOCK_EQ, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, BLOCK_A, 1'b0);
        end
        applyStimulus(1'b0, BLOCK_A, 1'b0);
        checkOutput("eq_done", {31'h0, done}, 32'h1);

        $display("[TB] full toggling");
        pushBlock(A0, A1, A2, A3);
        applyStimulus(1'b1, BLOCK_A, 1'b0);
        doneSeen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, BLOCK_A, (i % 2) == 0);
            if (done) begin
                doneSeen = 1'b1;
                break;
            end
        end
        checkOutput("toggle_done_within_bound", {31'h0, doneSeen}, 32'h1);

        applyStimulus(1'b0, BLOCK_A, 1'b0);
        checkOutput("final_queue_drained", expectQ.size(), 32'h0);
        checkOutput("final_idle_busy", {31'h0, busy}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
